// File: rtl/desq_pkg.sv
// ----------------------------------------------------------------------------
// desq_pkg
//
// Shared types and width helpers for the deser_queue block.
//
// Contents:
//   des_state_t  - deserializer FSM state (RX accepting bits, WAIT holding a
//                  completed word until the queue takes or drops it)
//   cnt_width    - bit-count width for a WIDTH-bit word, $clog2(WIDTH)
//   ptr_width    - read/write pointer width for a DEPTH-entry queue
//   len_width    - occupancy width, wide enough to hold DEPTH itself
//   div_width    - tick counter width for a 0..DIV-1 counter
//
// All helpers clamp to at least one bit so degenerate parameters still
// elaborate to legal vectors.
// ----------------------------------------------------------------------------
package desq_pkg;

    typedef enum logic [0:0] {
        RX   = 1'b0,
        WAIT = 1'b1
    } des_state_t;

    // The bit count runs 0..WIDTH-1 and clears on the last bit, so it never
    // has to represent WIDTH.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy must reach DEPTH, hence DEPTH+1 codes.
    function automatic int unsigned len_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned div_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/deser_queue_tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
//
// Clock-enable generator. A free-running counter steps 0..DIV-1 and the tick
// output is high for exactly one clock1M cycle while the counter sits at
// DIV-1, after which the counter wraps to 0. Used in place of a divided clock
// so the whole block stays in the single clock1M domain.
//
// Parameters:
//   DIV      - clock1M cycles per tick (>= 1)
//
// Ports:
//   clock1M  in   sole clock, rising edge
//   reset    in   synchronous, active-low; clears the counter
//   tick     out  one-cycle enable pulse, once every DIV cycles
// ----------------------------------------------------------------------------
module tick_gen
    import desq_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic clock1M,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CntW = div_width(DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clock1M) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (cnt_q == CntLast) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    // Decoded straight from the counter register, so the pulse is glitch-free
    // relative to the clock and exactly one cycle wide.
    assign tick = (cnt_q == CntLast);

endmodule

// File: rtl/deser_queue.sv
// ----------------------------------------------------------------------------
// deser_queue
//
// Single-clock serial-to-parallel receiver feeding a circular word queue.
// Serial bits (MSB first) are sampled on a deserializer tick; a completed
// word is parked as pending and handed to the queue on a later queue tick.
// Both ticks are clock enables derived from clock1M by tick_gen instances.
//
// Parameters:
//   WIDTH    - bits per word (>= 2)
//   DEPTH    - queue entries (>= 2, any value)
//   DIV_DES  - clock1M cycles per deserializer tick
//   DIV_Q    - clock1M cycles per queue tick
//
// Ports:
//   clock1M      in   sole clock, rising edge
//   reset        in   synchronous, active-low
//   data_in      in   serial bit, MSB first
//   write_in     in   qualifies data_in on a deserializer tick
//   dequeue_in   in   pop request, sampled on a queue tick
//   data_out     out  last popped word
//   data_valid   out  one-cycle pulse when data_out is updated
//   status_out   out  1 while the deserializer accepts bits
//   len_out      out  queue occupancy
//   full_out     out  len_out == DEPTH
//   empty_out    out  len_out == 0
//   overflow_out out  sticky dropped-word flag
//
// Build option:
//   DESQ_OVERFLOW_DROP_EN - when defined, a completed word that meets a full
//   queue at its first queue tick is discarded, overflow_out is set until
//   reset, and the receiver immediately resumes. When undefined, the
//   receiver stalls in WAIT until space exists and overflow_out is 0.
// ----------------------------------------------------------------------------
module deser_queue
    import desq_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DIV_DES = 10,
    parameter int unsigned DIV_Q   = 100
) (
    input  logic                         clock1M,
    input  logic                         reset,
    input  logic                         data_in,
    input  logic                         write_in,
    input  logic                         dequeue_in,
    output logic [WIDTH-1:0]             data_out,
    output logic                         data_valid,
    output logic                         status_out,
    output logic [len_width(DEPTH)-1:0]  len_out,
    output logic                         full_out,
    output logic                         empty_out,
    output logic                         overflow_out
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam int unsigned PtrW = ptr_width(DEPTH);
    localparam int unsigned LenW = len_width(DEPTH);

    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
    localparam logic [LenW-1:0] LenFull = LenW'(DEPTH);

    // ------------------------------------------------------------------
    // Clock-enable ticks
    // ------------------------------------------------------------------
    logic des_tick;
    logic q_tick;

    tick_gen #(
        .DIV (DIV_DES)
    ) u_des_tick (
        .clock1M (clock1M),
        .reset   (reset),
        .tick    (des_tick)
    );

    tick_gen #(
        .DIV (DIV_Q)
    ) u_q_tick (
        .clock1M (clock1M),
        .reset   (reset),
        .tick    (q_tick)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    des_state_t      state_q;
    logic [CntW-1:0] bit_cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] pending_q;
    logic            status_q;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [LenW-1:0]  len_q;
    logic [LenW-1:0]  len_d;
    logic             full_q;
    logic             empty_q;
    logic [WIDTH-1:0] data_out_q;
    logic             data_valid_q;

    logic [WIDTH-1:0] shift_next;
    logic             pending;
    logic             do_deq;
    logic             do_enq;
    logic             do_drop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == PtrLast) ? '0 : ptr + PtrW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Queue action decode
    // ------------------------------------------------------------------
    always_comb begin
        shift_next = {shift_q[WIDTH-2:0], data_in};
        pending    = (state_q == WAIT);
        do_deq     = q_tick && dequeue_in && !empty_q;
        // A full queue still accepts the pending word when the same tick pops
        // the head; an empty queue never bypasses the word straight out.
        do_enq     = q_tick && pending && (!full_q || do_deq);
`ifdef DESQ_OVERFLOW_DROP_EN
        do_drop    = q_tick && pending && full_q && !do_deq;
`else
        do_drop    = 1'b0;
`endif
    end

    always_comb begin
        len_d = len_q;
        unique case ({do_enq, do_deq})
            2'b10:   len_d = len_q + LenW'(1);
            2'b01:   len_d = len_q - LenW'(1);
            default: len_d = len_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Deserializer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock1M) begin
        if (!reset) begin
            state_q   <= RX;
            status_q  <= 1'b1;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            pending_q <= '0;
        end else begin
            unique case (state_q)
                RX: begin
                    // A tick with write_in low leaves the partial word intact.
                    if (des_tick && write_in) begin
                        shift_q <= shift_next;
                        if (bit_cnt_q == CntLast) begin
                            pending_q <= shift_next;
                            bit_cnt_q <= '0;
                            state_q   <= WAIT;
                            status_q  <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CntW'(1);
                        end
                    end
                end
                WAIT: begin
                    if (do_enq || do_drop) begin
                        state_q  <= RX;
                        status_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= RX;
                    status_q <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Queue storage; contents need no reset because the pointers do.
    // ------------------------------------------------------------------
    always_ff @(posedge clock1M) begin
        if (do_enq) begin
            mem_q[wr_ptr_q] <= pending_q;
        end
    end

    always_ff @(posedge clock1M) begin
        if (!reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            len_q        <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= do_deq;
            if (do_deq) begin
                data_out_q <= mem_q[rd_ptr_q];
                rd_ptr_q   <= next_ptr(rd_ptr_q);
            end
            if (do_enq) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            // Flags derive from the same next value as len_q so all three
            // registers always agree.
            len_q   <= len_d;
            full_q  <= (len_d == LenFull);
            empty_q <= (len_d == '0);
        end
    end

`ifdef DESQ_OVERFLOW_DROP_EN
    logic overflow_q;

    always_ff @(posedge clock1M) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if (do_drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow_out = overflow_q;
`else
    assign overflow_out = 1'b0;
`endif

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign status_out = status_q;
    assign len_out    = len_q;
    assign full_out   = full_q;
    assign empty_out  = empty_q;

endmodule

// File: tb/tb_deser_queue.sv
// ----------------------------------------------------------------------------
// tb_deser_queue
//
// Self-checking bench for deser_queue (WIDTH=8, DEPTH=4, DIV_DES=2, DIV_Q=4).
// Words expected to leave the queue are pushed to a scoreboard as they are
// shifted in; a monitor pops and compares on every data_valid pulse.
// Each serial bit is held for DIV_DES clocks and each pop request for DIV_Q
// clocks, so exactly one tick samples it regardless of counter phase.
// Honours DESQ_OVERFLOW_DROP_EN for the full-queue expectations.
// ----------------------------------------------------------------------------
module tb_deser_queue;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned DIV_DES = 2;
    localparam int unsigned DIV_Q   = 4;
    localparam int unsigned LenW    = $clog2(DEPTH + 1);

    logic             clock1M    = 1'b0;
    logic             reset      = 1'b0;
    logic             data_in    = 1'b0;
    logic             write_in   = 1'b0;
    logic             dequeue_in = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             status_out;
    logic [LenW-1:0]  len_out;
    logic             full_out;
    logic             empty_out;
    logic             overflow_out;

    int unsigned      n_checks = 0;
    int unsigned      n_errors = 0;
    logic [WIDTH-1:0] sb [$];
    logic             dv_prev  = 1'b0;
    logic [WIDTH-1:0] last_w;

    always #5 clock1M = ~clock1M;

    deser_queue #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .DIV_DES (DIV_DES),
        .DIV_Q   (DIV_Q)
    ) dut (
        .clock1M      (clock1M),
        .reset        (reset),
        .data_in      (data_in),
        .write_in     (write_in),
        .dequeue_in   (dequeue_in),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .status_out   (status_out),
        .len_out      (len_out),
        .full_out     (full_out),
        .empty_out    (empty_out),
        .overflow_out (overflow_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clock1M) begin
        if (reset) begin
            if (dv_prev) check("dv_pulse", 32'(data_valid), 32'd0);
            if (data_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_dv", 32'(data_valid), 32'd0);
                end else begin
                    check("data_out", 32'(data_out), 32'(sb.pop_front()));
                end
            end
        end
        dv_prev = data_valid;
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clock1M);
            #1;
        end
    endtask

    task automatic wait_status(input logic val);
        int i = 0;
        while (status_out !== val && i < 200) begin
            cycles(1);
            i++;
        end
        check("status_wait", 32'(status_out), 32'(val));
    endtask

    task automatic wait_len(input int exp, input string tag);
        int i = 0;
        while (len_out !== LenW'(exp) && i < 200) begin
            cycles(1);
            i++;
        end
        check({tag, "_len"}, 32'(len_out), 32'(exp));
        check({tag, "_full"}, 32'(full_out), 32'(exp == DEPTH));
        check({tag, "_empty"}, 32'(empty_out), 32'(exp == 0));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_data_out"}, 32'(data_out), 32'd0);
        check({tag, "_dv"}, 32'(data_valid), 32'd0);
        check({tag, "_status"}, 32'(status_out), 32'd1);
        check({tag, "_len"}, 32'(len_out), 32'd0);
        check({tag, "_full"}, 32'(full_out), 32'd0);
        check({tag, "_empty"}, 32'(empty_out), 32'd1);
        check({tag, "_ovf"}, 32'(overflow_out), 32'd0);
    endtask

    // Shift the first nbits of w MSB first; after pause_after bits, drop
    // write_in for pause_ticks deserializer ticks with junk on data_in.
    task automatic send_bits(input logic [WIDTH-1:0] w, input int nbits,
                             input int pause_after, input int pause_ticks);
        for (int i = 0; i < nbits; i++) begin
            if (i == pause_after && pause_ticks > 0) begin
                write_in = 1'b0;
                for (int p = 0; p < pause_ticks * int'(DIV_DES); p++) begin
                    data_in = 1'($urandom);
                    cycles(1);
                end
            end
            data_in  = w[WIDTH-1-i];
            write_in = 1'b1;
            cycles(DIV_DES);
        end
        write_in = 1'b0;
        data_in  = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input logic expect_out);
        wait_status(1'b1);
        if (expect_out) sb.push_back(w);
        send_bits(w, WIDTH, WIDTH, 0);
    endtask

    task automatic pop();
        dequeue_in = 1'b1;
        cycles(DIV_Q);
        dequeue_in = 1'b0;
        cycles(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        reset = 1'b0;
        cycles(3);
        check_reset("rst");
        reset = 1'b1;

        // Single word round trip
        send_word(8'hA5, 1'b1);
        wait_len(1, "t1_in");
        pop();
        wait_len(0, "t1_out");

        // write_in gap mid-word
        wait_status(1'b1);
        sb.push_back(8'h3C);
        send_bits(8'h3C, WIDTH, 4, 3);
        wait_len(1, "t2_in");
        pop();
        wait_len(0, "t2_out");

        // Fill, drain in order, then wrap
        for (int k = 1; k <= 4; k++) send_word(8'(k), 1'b1);
        wait_len(4, "t3_fill");
        for (int k = 0; k < 4; k++) pop();
        wait_len(0, "t3_drain");
        send_word(8'h05, 1'b1);
        wait_len(1, "t3_wrap");
        pop();
        wait_len(0, "t3_wrap_out");

        // Word arriving at a full queue
        for (int k = 0; k < 4; k++) send_word(8'h11 + 8'(k), 1'b1);
        wait_len(4, "t4_fill");
`ifdef DESQ_OVERFLOW_DROP_EN
        send_word(8'h77, 1'b0);
        cycles(3 * DIV_Q);
        check("t4_status", 32'(status_out), 32'd1);
        check("t4_ovf", 32'(overflow_out), 32'd1);
        wait_len(4, "t4_drop");
        last_w = 8'h14;
`else
        send_word(8'h77, 1'b1);
        cycles(3 * DIV_Q);
        check("t4_status", 32'(status_out), 32'd0);
        check("t4_ovf", 32'(overflow_out), 32'd0);
        wait_len(4, "t4_stall");
        // Pop and pending enqueue share the tick: occupancy stays at DEPTH.
        pop();
        check("t4_simul_len", 32'(len_out), 32'(DEPTH));
        check("t4_simul_full", 32'(full_out), 32'd1);
        wait_status(1'b1);
        last_w = 8'h77;
`endif
        for (int k = 0; k < 4; k++) pop();
        wait_len(0, "t4_drain");

        // Pop request on an empty queue
        pop();
        cycles(2);
        check("t5_hold", 32'(data_out), 32'(last_w));
        wait_len(0, "t5_empty");

        // Reset with queued words and a partial word in flight
        send_word(8'hC1, 1'b0);
        send_word(8'hC2, 1'b0);
        wait_len(2, "t6_queued");
        wait_status(1'b1);
        send_bits(8'h5A, 5, WIDTH, 0);
        reset = 1'b0;
        cycles(1);
        check_reset("t6_rst");
        reset = 1'b1;
        send_word(8'hFF, 1'b1);
        wait_len(1, "t6_ff");
        pop();
        wait_len(0, "t6_end");
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
